// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - fetch-address stage: generates pc/ce for the instruction ROM
// Handles stalls, branch redirects (held while stalled), flushes and misalignment flagging.
module pc_fetch #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stop,
    input  logic              branch_flag,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              flush,
    input  logic [DATA_W-1:0] flush_target,
    output logic [DATA_W-1:0] pc,
    output logic              ce,
    output logic              fetch_adel
);

    localparam logic [DATA_W-1:0] STEP     = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] START_PC = DATA_W'(RESET_PC);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              pending_q, pending_d;
    logic              ce_q;
    logic              adel_q, adel_d;

    // ce doubles as the OFF/RUN state; while OFF nothing but the OFF->RUN step happens
    always_comb begin
        pc_d       = pc_q;
        pending_d  = pending_q;
        pend_tgt_d = pend_tgt_q;
        if (ce_q) begin
            if (flush) begin
                pc_d      = flush_target;
                pending_d = 1'b0;
            end else if (stop[0]) begin
                if (branch_flag) begin
                    pending_d  = 1'b1;
                    pend_tgt_d = branch_target;
                end
            end else if (branch_flag) begin
                pc_d      = branch_target;
                pending_d = 1'b0;
            end else if (pending_q) begin
                pc_d      = pend_tgt_q;
                pending_d = 1'b0;
            end else begin
                pc_d = pc_q + STEP;
            end
        end
        adel_d = |pc_d[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q       <= 1'b0;
            pc_q       <= START_PC;
            adel_q     <= 1'b0;
            pending_q  <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            ce_q       <= 1'b1;
            pc_q       <= pc_d;
            adel_q     <= adel_d;
            pending_q  <= pending_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc         = pc_q;
    assign ce         = ce_q;
    assign fetch_adel = adel_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed bench for pc_fetch with a per-cycle reference model
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stop;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_target;
    logic [31:0] pc;
    logic        ce;
    logic        fetch_adel;

    int tests = 0;
    int fails = 0;

    pc_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stop         (stop),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .flush        (flush),
        .flush_target (flush_target),
        .pc           (pc),
        .ce           (ce),
        .fetch_adel   (fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: fetch address as a plain integer plus an optional saved redirect
    logic        m_run = 1'b0;
    logic [31:0] m_pc  = 32'h0;
    logic        m_has_saved = 1'b0;
    logic [31:0] m_saved = 32'h0;
    logic        started = 1'b0;
    logic        done = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_run = 1'b0; m_pc = 32'h0; m_has_saved = 1'b0; m_saved = 32'h0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (flush) begin
            m_pc = flush_target; m_has_saved = 1'b0;
        end else if (stop[0]) begin
            if (branch_flag) begin
                m_has_saved = 1'b1; m_saved = branch_target;
            end
        end else if (branch_flag) begin
            m_pc = branch_target; m_has_saved = 1'b0;
        end else if (m_has_saved) begin
            m_pc = m_saved; m_has_saved = 1'b0;
        end else begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
    end

    always @(negedge clk) begin
        if (started && !done) begin
            tests++;
            if (ce !== m_run || pc !== m_pc || fetch_adel !== (m_pc % 4 != 0)) begin
                fails++;
                $display("FAIL model t=%0t ce=%b pc=%h adel=%b required ce=%b pc=%h adel=%b",
                         $time, ce, pc, fetch_adel, m_run, m_pc, (m_pc % 4 != 0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stop = '0; branch_flag = 1'b0; branch_target = '0;
        flush = 1'b0; flush_target = '0;
        // T1 reset release
        repeat (3) step();
        chk("t1_rst_ce", 32'(ce), 32'h0);
        chk("t1_rst_pc", pc, 32'h0);
        rst = 1'b0;
        chk("t1_rel_ce", 32'(ce), 32'h0);
        step(); chk("t1_ce1", 32'(ce), 32'h1); chk("t1_pc0", pc, 32'h0);
        step(); chk("t1_pc4", pc, 32'h4);
        step(); chk("t1_pc8", pc, 32'h8);
        // T2 wrap
        flush = 1'b1; flush_target = 32'hFFFF_FFF8;
        step(); chk("t2_f8", pc, 32'hFFFF_FFF8);
        flush = 1'b0;
        step(); chk("t2_fc", pc, 32'hFFFF_FFFC);
        step(); chk("t2_wrap", pc, 32'h0);
        step(); chk("t2_4", pc, 32'h4);
        // T3 branch during stall
        flush = 1'b1; flush_target = 32'h10;
        step(); flush = 1'b0;
        stop = 6'b000001; branch_flag = 1'b1; branch_target = 32'h200;
        step(); chk("t3_hold1", pc, 32'h10);
        branch_flag = 1'b0;
        step(); chk("t3_hold2", pc, 32'h10);
        step(); chk("t3_hold3", pc, 32'h10);
        stop = '0;
        step(); chk("t3_redir", pc, 32'h200);
        step(); chk("t3_seq", pc, 32'h204);
        // T4 pending overwrite, then live branch beats pending
        stop = 6'b000001; branch_flag = 1'b1; branch_target = 32'h100;
        step(); branch_target = 32'h300;
        step(); chk("t4_hold", pc, 32'h204);
        stop = '0; branch_flag = 1'b0;
        step(); chk("t4_newest", pc, 32'h300);
        stop = 6'b000001; branch_flag = 1'b1; branch_target = 32'h100;
        step(); branch_target = 32'h300;
        step(); stop = '0; branch_target = 32'h500;
        step(); chk("t4_live", pc, 32'h500);
        branch_flag = 1'b0;
        step(); chk("t4_seq", pc, 32'h504);
        // T5 flush dominance
        stop = 6'b000001; branch_flag = 1'b1; branch_target = 32'h600;
        step(); branch_flag = 1'b0; flush = 1'b1; flush_target = 32'h380;
        step(); chk("t5_flush", pc, 32'h380);
        flush = 1'b0;
        step(); chk("t5_hold", pc, 32'h380);
        stop = '0;
        step(); chk("t5_nopend", pc, 32'h384);
        step(); chk("t5_seq", pc, 32'h388);
        // T6 misalignment
        branch_flag = 1'b1; branch_target = 32'h102;
        step(); chk("t6_pc", pc, 32'h102); chk("t6_adel", 32'(fetch_adel), 32'h1);
        branch_flag = 1'b0;
        step(); chk("t6_seq", pc, 32'h106); chk("t6_adel2", 32'(fetch_adel), 32'h1);
        flush = 1'b1; flush_target = 32'h380;
        step(); chk("t6_fl", pc, 32'h380); chk("t6_adel0", 32'(fetch_adel), 32'h0);
        flush = 1'b0;
        // Mid-run reset discards pending; branch ignored while OFF
        stop = 6'b000001; branch_flag = 1'b1; branch_target = 32'h700;
        step(); rst = 1'b1; stop = '0; branch_flag = 1'b0;
        step(); chk("rs_ce", 32'(ce), 32'h0); chk("rs_pc", pc, 32'h0);
        rst = 1'b0; branch_flag = 1'b1; branch_target = 32'h900;
        step(); chk("rs_run", 32'(ce), 32'h1); chk("rs_off_br", pc, 32'h0);
        branch_flag = 1'b0;
        step(); chk("rs_seq", pc, 32'h4);
        step();
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
